// File: rtl/regdump_pkg.sv
// regdump_pkg: shared types and sizes for the register file dump reader.
package regdump_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam int REGDUMP_BYTES = REG_DATA_W / 8;
  typedef enum logic [1:0] {IDLE, READ, SEND, DONE} regdump_state_t;
endpackage

// File: rtl/regfile_dump_reader_serializer.sv
// word_byte_serializer: loads a word and emits it LSB-first as valid/ready bytes.
module word_byte_serializer #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              clear,
  input  logic [DATA_W-1:0] word,
  output logic [7:0]        m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              last_hs
);
  localparam int NB = DATA_W / 8;
  localparam int IW = NB > 1 ? $clog2(NB) : 1;
  logic [DATA_W-1:0] shift;
  logic [IW-1:0] idx;
  logic hs;
  assign hs = m_valid && m_ready;
  assign last_hs = hs && idx == IW'(NB - 1);
  assign m_data = shift[7:0];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift <= '0;
      idx <= '0;
      m_valid <= 1'b0;
    end else if (clear) begin
      m_valid <= 1'b0;
    end else if (load) begin
      shift <= word;
      idx <= '0;
      m_valid <= 1'b1;
    end else if (hs) begin
      shift <= shift >> 8;
      idx <= idx + IW'(1);
      if (last_hs) m_valid <= 1'b0;
    end
  end
endmodule

// File: rtl/regfile_dump_reader.sv
// regfile_dump_reader: walks a register range through a read port and streams
// each snapshotted register out as little-endian bytes.
module regfile_dump_reader
  import regdump_pkg::*;
#(
  parameter int DATA_W = REG_DATA_W,
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] first_reg,
  input  logic [ADDR_W-1:0] last_reg,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic [7:0]        m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              busy,
  output logic              done,
  output logic              err_range
);
  regdump_state_t state;
  logic [ADDR_W-1:0] cur, last;
  logic load, last_hs;
  assign rd_addr = cur;
  assign load = state == READ && !abort;
  word_byte_serializer #(.DATA_W(DATA_W)) ser (
    .clk(clk), .rst_n(rst_n), .load(load), .clear(abort), .word(rd_data),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .last_hs(last_hs)
  );
  // cur == last is tested before incrementing so a range ending at the top index never wraps
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cur <= '0;
      last <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      err_range <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          cur <= first_reg;
          last <= last_reg;
          err_range <= first_reg > last_reg;
          if (first_reg > last_reg) done <= 1'b1;
          else begin
            state <= READ;
            busy <= 1'b1;
          end
        end
      end else if (abort) begin
        state <= IDLE;
        busy <= 1'b0;
      end else if (state == READ) begin
        state <= SEND;
      end else if (state == SEND) begin
        if (last_hs) begin
          if (cur == last) begin
            state <= DONE;
            done <= 1'b1;
          end else begin
            cur <= cur + 1'b1;
            state <= READ;
          end
        end
      end else begin
        state <= IDLE;
        busy <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_regfile_dump_reader.sv
// tb_regfile_dump_reader: scoreboard bench; expected bytes are queued at start
// and popped as the DUT hands them over.
module tb_regfile_dump_reader;
  logic clk = 0, rst_n = 0, start = 0, abort = 0, m_ready = 1;
  logic [4:0] first_reg = 0, last_reg = 0, rd_addr;
  logic [31:0] rd_data;
  logic [7:0] m_data;
  logic m_valid, busy, done, err_range;
  logic [31:0] regs [32];
  logic [7:0] exp_q [$];
  int tests = 0, fails = 0, done_cnt = 0;
  logic prev_stall = 0;
  logic [7:0] prev_data = 0;
  always #5 clk = ~clk;
  assign rd_data = regs[rd_addr];
  regfile_dump_reader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .first_reg(first_reg), .last_reg(last_reg), .rd_addr(rd_addr), .rd_data(rd_data),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .busy(busy), .done(done), .err_range(err_range)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  always @(negedge clk) begin
    if (prev_stall) begin
      check("hold_valid", {31'd0, m_valid}, 1);
      check("hold_data", {24'd0, m_data}, {24'd0, prev_data});
    end
    if (done) done_cnt++;
    if (m_valid && m_ready) begin
      if (exp_q.size() == 0) check("extra_byte", 1, 0);
      else check("byte", {24'd0, m_data}, {24'd0, exp_q.pop_front()});
    end
    prev_stall = m_valid && !m_ready;
    prev_data = m_data;
  end
  task automatic push_range(input int f, input int l);
    for (int r = f; r <= l; r++)
      for (int b = 0; b < 4; b++) exp_q.push_back(regs[r][8*b +: 8]);
  endtask
  task automatic do_start(input logic [4:0] f, input logic [4:0] l);
    @(posedge clk); #1;
    first_reg = f; last_reg = l; start = 1;
    @(posedge clk); #1;
    start = 0;
  endtask
  task automatic wait_done(input string tag, input bit bp);
    int n;
    n = 0;
    while (!done && n < 2000) begin
      @(posedge clk); #1;
      if (bp) m_ready = 1'($urandom_range(0, 1));
      n++;
    end
    m_ready = 1;
    check({tag, "_timeout"}, {31'd0, n < 2000}, 1);
    check({tag, "_busy_in_done"}, {31'd0, busy}, 1);
    @(posedge clk); #1;
    check({tag, "_done_low"}, {31'd0, done}, 0);
    check({tag, "_busy_low"}, {31'd0, busy}, 0);
    check({tag, "_q_empty"}, exp_q.size(), 0);
  endtask
  task automatic run(input string tag, input logic [4:0] f, input logic [4:0] l, input bit bp);
    int d0;
    push_range(f, l);
    d0 = done_cnt;
    do_start(f, l);
    check({tag, "_busy"}, {31'd0, busy}, 1);
    check({tag, "_no_valid_read"}, {31'd0, m_valid}, 0);
    if (!bp) begin
      @(posedge clk); #1;
      check({tag, "_first_valid"}, {31'd0, m_valid}, 1);
    end
    wait_done(tag, bp);
    check({tag, "_done_once"}, done_cnt - d0, 1);
    check({tag, "_err"}, {31'd0, err_range}, 0);
  endtask
  initial begin
    int d0;
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int d0;
    for (int i = 0; i < 32; i++) regs[i] = 32'h0101_0101 * i ^ 32'h5A00_00A5;
    regs[0] = 0;
    regs[1] = 32'h0102_0304;
    regs[2] = 32'h7FFF_F000;
    regs[3] = 32'hDEAD_BEEF;
    regs[4] = 32'h0BAD_F00D;
    regs[5] = 32'h1122_3344;
    regs[6] = 32'hAABB_CCDD;
    regs[10] = 32'hCAFE_BABE;
    regs[31] = 32'h1000_0000;
    repeat (2) @(posedge clk);
    #1;
    check("rst_rd_addr", {27'd0, rd_addr}, 0);
    check("rst_m_data", {24'd0, m_data}, 0);
    check("rst_m_valid", {31'd0, m_valid}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_done", {31'd0, done}, 0);
    check("rst_err", {31'd0, err_range}, 0);
    rst_n = 1;
    run("r5_6", 5, 6, 0);
    run("r0_0", 0, 0, 0);
    run("r31", 31, 31, 0);
    run("bp2_4", 2, 4, 1);
    d0 = done_cnt;
    do_start(7, 3);
    check("err_done", {31'd0, done}, 1);
    check("err_flag", {31'd0, err_range}, 1);
    check("err_no_valid", {31'd0, m_valid}, 0);
    check("err_busy", {31'd0, busy}, 0);
    @(posedge clk); #1;
    check("err_done_pulse", {31'd0, done}, 0);
    check("err_sticky", {31'd0, err_range}, 1);
    check("err_valid_after", {31'd0, m_valid}, 0);
    run("clr_err", 0, 0, 0);
    exp_q.push_back(8'hBE); exp_q.push_back(8'hBA); exp_q.push_back(8'hFE);
    d0 = done_cnt;
    do_start(10, 10);
    repeat (3) begin @(posedge clk); #1; end
    abort = 1;
    @(posedge clk); #1;
    abort = 0;
    check("abort_valid", {31'd0, m_valid}, 0);
    check("abort_busy", {31'd0, busy}, 0);
    check("abort_q", exp_q.size(), 0);
    repeat (3) @(posedge clk);
    #1;
    check("abort_no_done", done_cnt - d0, 0);
    run("after_abort", 1, 1, 0);
    push_range(2, 4);
    d0 = done_cnt;
    do_start(2, 4);
    repeat (6) @(posedge clk);
    #1;
    rst_n = 0;
    #2;
    check("mid_rst_valid", {31'd0, m_valid}, 0);
    check("mid_rst_busy", {31'd0, busy}, 0);
    check("mid_rst_data", {24'd0, m_data}, 0);
    check("mid_rst_addr", {27'd0, rd_addr}, 0);
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1;
    repeat (3) @(posedge clk);
    #1;
    check("mid_rst_no_done", done_cnt - d0, 0);
    run("after_rst", 1, 1, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
